// File: rtl/mc_pkg.sv
// Shared definitions for the AXI write-frame path: FSM encodings, frame
// bit positions and B response codes. The frame layout (from MSB down) is
// {sof, eof, wr_flag, addr, data}. The same layout is decoded by the array
// write controller.
package mc_pkg;

  // Write-channel FSM encoding
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    RESP = 2'd2
  } wr_state_e;

  // Frame bit positions for the default configuration (20-bit addr, 64-bit data)
  localparam int FRAME_W_DEFAULT = 87;
  localparam int SOF_BIT         = FRAME_W_DEFAULT - 1;
  localparam int EOF_BIT         = FRAME_W_DEFAULT - 2;
  localparam int WR_BIT          = FRAME_W_DEFAULT - 3;

  // B response codes
  localparam logic [1:0] BRESP_OKAY   = 2'b00;
  localparam logic [1:0] BRESP_SLVERR = 2'b10;

  // Control-bit positions for an arbitrary frame width
  function automatic int sof_bit(input int frame_w);
    return frame_w - 1;
  endfunction

  function automatic int eof_bit(input int frame_w);
    return frame_w - 2;
  endfunction

  function automatic int wr_bit(input int frame_w);
    return frame_w - 3;
  endfunction

endpackage

// File: rtl/axi_wr_frame_gen_wr_frame_reg.sv
// Single-entry valid/ready output register for the write-frame path.
// A load always wins over a same-cycle drain, which gives back-to-back
// frames with no bubble. Data is held unchanged while valid && !ready.
module wr_frame_reg #(
  parameter int WIDTH = 87
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data_out
);

  // Frame holding register: load new frame, or drop valid once accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid    <= 1'b0;
      data_out <= {WIDTH{1'b0}};
    end else if (load) begin
      valid    <= 1'b1;
      data_out <= data_in;
    end else if (ready) begin
      valid    <= 1'b0;
    end
  end

endmodule

// File: rtl/axi_wr_frame_gen.sv
// AXI4 write-channel front end for the array write controller.
// Accepts one INCR AW burst and its W beats, emits one frame per beat and
// splits the burst at row boundaries (sof at column 0, eof at the last
// column). B is returned once the final frame has left the output register.
// Optional build macro AXI_WR_FRAME_ID_EN adds axi_awid / axi_bid.
module axi_wr_frame_gen
  import mc_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH  = 20,
  parameter int AXI_DATA_WIDTH  = 64,
  parameter int AXI_FRAME_WIDTH = AXI_ADDR_WIDTH + AXI_DATA_WIDTH + 3,
  parameter int AXI_RADDR_WIDTH = 14,
  parameter int AXI_CADDR_WIDTH = AXI_ADDR_WIDTH - AXI_RADDR_WIDTH,
  parameter int AXI_ID_WIDTH    = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       axi_awvalid,
  output logic                       axi_awready,
  input  logic [AXI_ADDR_WIDTH-1:0]  axi_awaddr,
  input  logic [7:0]                 axi_awlen,
  input  logic                       axi_wvalid,
  output logic                       axi_wready,
  input  logic [AXI_DATA_WIDTH-1:0]  axi_wdata,
  input  logic                       axi_wlast,
  output logic                       axi_bvalid,
  input  logic                       axi_bready,
  output logic [1:0]                 axi_bresp,
  output logic [AXI_FRAME_WIDTH-1:0] axi_frame_wr_data,
  output logic                       axi_frame_wr_valid,
  input  logic                       axi_frame_wr_ready
`ifdef AXI_WR_FRAME_ID_EN
  ,
  input  logic [AXI_ID_WIDTH-1:0]    axi_awid,
  output logic [AXI_ID_WIDTH-1:0]    axi_bid
`endif
);

  localparam int SOF_B = sof_bit(AXI_FRAME_WIDTH);
  localparam int EOF_B = eof_bit(AXI_FRAME_WIDTH);
  localparam int WR_B  = wr_bit(AXI_FRAME_WIDTH);

  wr_state_e                  state_r;
  wr_state_e                  state_nxt_s;
  logic [AXI_ADDR_WIDTH-1:0]  addr_cnt_r;
  logic [7:0]                 beat_cnt_r;
  logic [7:0]                 len_r;
  logic                       err_r;
  logic                       first_r;
  logic                       awready_r;

  logic                       aw_hs_s;
  logic                       w_hs_s;
  logic                       wready_s;
  logic                       bvalid_s;
  logic                       len_done_s;
  logic                       last_beat_s;
  logic                       sof_s;
  logic                       eof_s;
  logic [AXI_CADDR_WIDTH-1:0] col_s;
  logic [AXI_FRAME_WIDTH-1:0] frame_in_s;
  logic                       frame_valid_s;

  // Handshakes, frame control bits and the frame word to be loaded
  always_comb begin
    aw_hs_s     = 1'b0;
    wready_s    = 1'b0;
    bvalid_s    = 1'b0;
    col_s       = addr_cnt_r[AXI_CADDR_WIDTH-1:0];
    len_done_s  = (beat_cnt_r == len_r);
    last_beat_s = len_done_s || axi_wlast;
    sof_s       = first_r || (col_s == {AXI_CADDR_WIDTH{1'b0}});
    eof_s       = last_beat_s || (col_s == {AXI_CADDR_WIDTH{1'b1}});
    if (state_r == IDLE) begin
      aw_hs_s = axi_awvalid && awready_r;
    end else begin
      aw_hs_s = 1'b0;
    end
    if (state_r == DATA) begin
      wready_s = !frame_valid_s || axi_frame_wr_ready;
    end else begin
      wready_s = 1'b0;
    end
    if (state_r == RESP) begin
      bvalid_s = !frame_valid_s;
    end else begin
      bvalid_s = 1'b0;
    end
    w_hs_s = axi_wvalid && wready_s;
    frame_in_s = {AXI_FRAME_WIDTH{1'b0}};
    frame_in_s[SOF_B] = sof_s;
    frame_in_s[EOF_B] = eof_s;
    frame_in_s[WR_B]  = 1'b1;
    frame_in_s[AXI_ADDR_WIDTH+AXI_DATA_WIDTH-1:AXI_DATA_WIDTH] = addr_cnt_r;
    frame_in_s[AXI_DATA_WIDTH-1:0] = axi_wdata;
  end

  // Next-state logic for the IDLE -> DATA -> RESP burst sequence
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (aw_hs_s) begin
          state_nxt_s = DATA;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      DATA: begin
        if (w_hs_s && last_beat_s) begin
          state_nxt_s = RESP;
        end else begin
          state_nxt_s = DATA;
        end
      end
      RESP: begin
        if (bvalid_s && axi_bready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RESP;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register; awready is registered so it stays low through reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      awready_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      awready_r <= (state_nxt_s == IDLE);
    end
  end

  // Burst bookkeeping: address/beat counters, first-beat flag, wlast error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_cnt_r <= {AXI_ADDR_WIDTH{1'b0}};
      beat_cnt_r <= 8'd0;
      len_r      <= 8'd0;
      err_r      <= 1'b0;
      first_r    <= 1'b0;
    end else if (aw_hs_s) begin
      addr_cnt_r <= axi_awaddr;
      beat_cnt_r <= 8'd0;
      len_r      <= axi_awlen;
      err_r      <= 1'b0;
      first_r    <= 1'b1;
    end else if (w_hs_s) begin
      addr_cnt_r <= addr_cnt_r + AXI_ADDR_WIDTH'(1);
      beat_cnt_r <= beat_cnt_r + 8'd1;
      first_r    <= 1'b0;
      if (axi_wlast != len_done_s) begin
        err_r <= 1'b1;
      end
    end
  end

  // B response code, driven only while bvalid is up
  always_comb begin
    axi_bresp = BRESP_OKAY;
    if (bvalid_s && err_r) begin
      axi_bresp = BRESP_SLVERR;
    end else begin
      axi_bresp = BRESP_OKAY;
    end
  end

`ifdef AXI_WR_FRAME_ID_EN
  logic [AXI_ID_WIDTH-1:0] id_r;

  // Capture the burst ID on the AW handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_r <= {AXI_ID_WIDTH{1'b0}};
    end else if (aw_hs_s) begin
      id_r <= axi_awid;
    end
  end

  // Present the captured ID alongside bvalid
  always_comb begin
    axi_bid = {AXI_ID_WIDTH{1'b0}};
    if (bvalid_s) begin
      axi_bid = id_r;
    end else begin
      axi_bid = {AXI_ID_WIDTH{1'b0}};
    end
  end
`endif

  assign axi_awready        = awready_r;
  assign axi_wready         = wready_s;
  assign axi_bvalid         = bvalid_s;
  assign axi_frame_wr_valid = frame_valid_s;

  wr_frame_reg #(
    .WIDTH (AXI_FRAME_WIDTH)
  ) u_frame_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (w_hs_s),
    .data_in  (frame_in_s),
    .ready    (axi_frame_wr_ready),
    .valid    (frame_valid_s),
    .data_out (axi_frame_wr_data)
  );

endmodule

// File: tb/tb_axi_wr_frame_gen.sv
// Directed bench for axi_wr_frame_gen: a table of bursts with hand-computed
// frame sof/eof/address and B response, plus hand-written reset sequences.
module tb_axi_wr_frame_gen;

  localparam int AW = 20;
  localparam int DW = 64;
  localparam int FW = AW + DW + 3;

  logic          clk;
  logic          rst_n;
  logic          axi_awvalid;
  logic          axi_awready;
  logic [AW-1:0] axi_awaddr;
  logic [7:0]    axi_awlen;
  logic          axi_wvalid;
  logic          axi_wready;
  logic [DW-1:0] axi_wdata;
  logic          axi_wlast;
  logic          axi_bvalid;
  logic          axi_bready;
  logic [1:0]    axi_bresp;
  logic [FW-1:0] axi_frame_wr_data;
  logic          axi_frame_wr_valid;
  logic          axi_frame_wr_ready;
`ifdef AXI_WR_FRAME_ID_EN
  logic [3:0]    axi_awid;
  logic [3:0]    axi_bid;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  axi_wr_frame_gen dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .axi_awvalid        (axi_awvalid),
    .axi_awready        (axi_awready),
    .axi_awaddr         (axi_awaddr),
    .axi_awlen          (axi_awlen),
    .axi_wvalid         (axi_wvalid),
    .axi_wready         (axi_wready),
    .axi_wdata          (axi_wdata),
    .axi_wlast          (axi_wlast),
    .axi_bvalid         (axi_bvalid),
    .axi_bready         (axi_bready),
    .axi_bresp          (axi_bresp),
    .axi_frame_wr_data  (axi_frame_wr_data),
    .axi_frame_wr_valid (axi_frame_wr_valid),
    .axi_frame_wr_ready (axi_frame_wr_ready)
`ifdef AXI_WR_FRAME_ID_EN
    ,
    .axi_awid           (axi_awid),
    .axi_bid            (axi_bid)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0]      awaddr;
    logic [7:0]         awlen;
    int                 nbeats;     // beats driven; wlast on the final one
    int                 stall_idx;  // frame index held 5 cycles, -1 = none
    logic [3:0]         sof;        // bit i = expected sof of frame i
    logic [3:0]         eof;
    logic [3:0][AW-1:0] addr;
    logic [1:0]         bresp;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk_data(input int v, input int b);
    logic [7:0] vv;
    logic [7:0] bb;
    vv = v[7:0];
    bb = b[7:0];
    return {48'hA5A5_A5A5_A5A5, vv, bb};
  endfunction

  // Called at posedge+1; returns at posedge+1 after the AW handshake edge
  task automatic do_aw(input logic [AW-1:0] a, input logic [7:0] l);
    int n;
    n = 0;
    axi_awvalid = 1'b1;
    axi_awaddr  = a;
    axi_awlen   = l;
`ifdef AXI_WR_FRAME_ID_EN
    axi_awid    = 4'h7;
`endif
    @(negedge clk);
    while (!axi_awready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("aw_accept", {127'd0, axi_awready}, 128'd1);
    @(posedge clk);
    #1;
    axi_awvalid = 1'b0;
  endtask

  task automatic run_vec(input int v);
    vec_t          t;
    int            beat;
    int            got;
    int            hold;
    int            cyc;
    int            n;
    logic [FW-1:0] held;
    logic [FW-1:0] exp_frame;
    logic          stall_ok;
    logic          b_early;
    t = vecs[v];
    do_aw(t.awaddr, t.awlen);
    beat = 0; got = 0; hold = 0; cyc = 0;
    stall_ok = 1'b1; b_early = 1'b0; held = '0;
    while (got < t.nbeats && cyc < 200) begin
      if (axi_frame_wr_valid && got == t.stall_idx && hold < 5) begin
        axi_frame_wr_ready = 1'b0;
      end else begin
        axi_frame_wr_ready = 1'b1;
      end
      if (beat < t.nbeats) begin
        axi_wvalid = 1'b1;
        axi_wdata  = mk_data(v, beat);
        axi_wlast  = (beat == t.nbeats - 1);
      end else begin
        axi_wvalid = 1'b0;
        axi_wlast  = 1'b0;
      end
      @(negedge clk);
      if (!axi_frame_wr_ready) begin
        if (hold == 0) held = axi_frame_wr_data;
        else if (axi_frame_wr_data !== held) stall_ok = 1'b0;
        if (axi_wready !== 1'b0) stall_ok = 1'b0;
        hold++;
      end
      if (axi_bvalid) b_early = 1'b1;
      if (axi_frame_wr_valid && axi_frame_wr_ready) begin
        exp_frame = {t.sof[got], t.eof[got], 1'b1, t.addr[got], mk_data(v, got)};
        check($sformatf("frame v%0d f%0d", v, got), 128'(axi_frame_wr_data), 128'(exp_frame));
        got++;
      end
      if (axi_wvalid && axi_wready) beat++;
      @(posedge clk);
      #1;
      cyc++;
    end
    axi_wvalid = 1'b0;
    axi_wlast  = 1'b0;
    axi_frame_wr_ready = 1'b1;
    check($sformatf("frame_count v%0d", v), 128'(got), 128'(t.nbeats));
    check($sformatf("beat_count v%0d", v), 128'(beat), 128'(t.nbeats));
    check($sformatf("b_before_last_frame v%0d", v), {127'd0, b_early}, 128'd0);
    if (t.stall_idx >= 0) begin
      check($sformatf("stall_stable v%0d", v), {127'd0, stall_ok}, 128'd1);
      check($sformatf("stall_cycles v%0d", v), 128'(hold), 128'd5);
    end
    axi_bready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!axi_bvalid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("bvalid v%0d", v), {127'd0, axi_bvalid}, 128'd1);
    check($sformatf("bresp v%0d", v), 128'(axi_bresp), 128'(t.bresp));
`ifdef AXI_WR_FRAME_ID_EN
    check($sformatf("bid v%0d", v), 128'(axi_bid), 128'h7);
`endif
    @(posedge clk);
    #1;
    axi_bready = 1'b0;
    @(negedge clk);
    check($sformatf("b_released v%0d", v), {127'd0, axi_bvalid}, 128'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_awready"},  {127'd0, axi_awready}, 128'd0);
    check({tag, "_wready"},   {127'd0, axi_wready}, 128'd0);
    check({tag, "_bvalid"},   {127'd0, axi_bvalid}, 128'd0);
    check({tag, "_bresp"},    128'(axi_bresp), 128'd0);
    check({tag, "_fvalid"},   {127'd0, axi_frame_wr_valid}, 128'd0);
    check({tag, "_fdata"},    128'(axi_frame_wr_data), 128'd0);
  endtask

  initial begin
    vecs[0] = '{awaddr: 20'h00010, awlen: 8'd0, nbeats: 1, stall_idx: -1,
                sof: 4'b0001, eof: 4'b0001,
                addr: {20'h0, 20'h0, 20'h0, 20'h00010}, bresp: 2'b00};
    vecs[1] = '{awaddr: 20'h0003E, awlen: 8'd3, nbeats: 4, stall_idx: -1,
                sof: 4'b0101, eof: 4'b1010,
                addr: {20'h00041, 20'h00040, 20'h0003F, 20'h0003E}, bresp: 2'b00};
    vecs[2] = '{awaddr: 20'h0003E, awlen: 8'd3, nbeats: 4, stall_idx: 2,
                sof: 4'b0101, eof: 4'b1010,
                addr: {20'h00041, 20'h00040, 20'h0003F, 20'h0003E}, bresp: 2'b00};
    vecs[3] = '{awaddr: 20'h00200, awlen: 8'd3, nbeats: 2, stall_idx: -1,
                sof: 4'b0001, eof: 4'b0010,
                addr: {20'h0, 20'h0, 20'h00201, 20'h00200}, bresp: 2'b10};
    vecs[4] = '{awaddr: 20'hFFFFF, awlen: 8'd1, nbeats: 2, stall_idx: -1,
                sof: 4'b0011, eof: 4'b0011,
                addr: {20'h0, 20'h0, 20'h00000, 20'hFFFFF}, bresp: 2'b00};

    rst_n = 1'b0;
    axi_awvalid = 1'b0; axi_awaddr = '0; axi_awlen = '0;
    axi_wvalid = 1'b0; axi_wdata = '0; axi_wlast = 1'b0;
    axi_bready = 1'b0; axi_frame_wr_ready = 1'b1;
`ifdef AXI_WR_FRAME_ID_EN
    axi_awid = 4'h0;
`endif
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int v = 0; v < 5; v++) begin
      run_vec(v);
    end

    // Reset in the middle of a 4-beat burst after two beats
    do_aw(20'h00100, 8'd3);
    for (int i = 0; i < 2; i++) begin
      axi_wvalid = 1'b1;
      axi_wdata  = mk_data(9, i);
      axi_wlast  = 1'b0;
      @(negedge clk);
      check($sformatf("mid_wready b%0d", i), {127'd0, axi_wready}, 128'd1);
      @(posedge clk);
      #1;
    end
    axi_wvalid = 1'b0;
    check("mid_fvalid_before_reset", {127'd0, axi_frame_wr_valid}, 128'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("midreset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_vec(0);
    run_vec(1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
